// File: rtl/vrc6_snd_gen.sv
// VRC6-style expansion audio: NUM_PULSE pulse channels, optional sawtooth and a saturating mixer.
// All state advances on the falling edge of m2.
module vrc6_snd_gen #(
    parameter int NUM_PULSE = 2,
    parameter int FREQ_W    = 12,
    parameter int SAW_EN    = 1,
    parameter int OUT_W     = 7
) (
    input  logic               m2,
    input  logic               map_rst_n,
    input  logic               reg_we,
    input  logic [2:0]         reg_ch,
    input  logic [1:0]         reg_idx,
    input  logic [7:0]         reg_data,
    output logic [OUT_W-1:0]   snd_out,
    output logic [NUM_PULSE:0] ch_active
);

    // Wide enough for NUM_PULSE*15+31 even when OUT_W is small.
    localparam int SUM_W = (OUT_W + 1 > 8) ? OUT_W + 1 : 8;

    logic halt_q;
    logic x16_q;
    logic x256_q;
    logic glb_wr;

    assign glb_wr = reg_we && (reg_idx == 2'd3);

    always_ff @(negedge m2) begin
        if (!map_rst_n) begin
            halt_q <= 1'b0;
            x16_q  <= 1'b0;
            x256_q <= 1'b0;
        end else if (glb_wr) begin
            halt_q <= reg_data[0];
            x16_q  <= reg_data[1];
            x256_q <= reg_data[2];
        end
    end

    logic [3:0]           pulse_lvl [NUM_PULSE];
    logic [NUM_PULSE-1:0] pulse_en;
    logic [4:0]           saw_lvl;
    logic                 saw_en;

    for (genvar g = 0; g < NUM_PULSE; g++) begin : g_pulse
        logic              ch_wr;
        logic              dis_wr;
        logic              mode_q;
        logic [2:0]        duty_q;
        logic [3:0]        vol_q;
        logic              en_q;
        logic [FREQ_W-1:0] per_q;
        logic [FREQ_W-1:0] per_eff;
        logic [FREQ_W-1:0] div_q;
        logic [3:0]        step_q;

        assign ch_wr   = reg_we && (reg_ch == 3'(g)) && (reg_idx != 2'd3);
        assign dis_wr  = ch_wr && (reg_idx == 2'd2) && !reg_data[7];
        assign per_eff = x256_q ? (per_q >> 8) : (x16_q ? (per_q >> 4) : per_q);

        always_ff @(negedge m2) begin
            if (!map_rst_n) begin
                mode_q <= 1'b0;
                duty_q <= 3'd0;
                vol_q  <= 4'd0;
                en_q   <= 1'b0;
                per_q  <= '0;
                div_q  <= '0;
                step_q <= 4'd0;
            end else begin
                if (ch_wr) begin
                    case (reg_idx)
                        2'd0: begin
                            mode_q <= reg_data[7];
                            duty_q <= reg_data[6:4];
                            vol_q  <= reg_data[3:0];
                        end
                        2'd1: per_q[7:0] <= reg_data;
                        2'd2: begin
                            en_q             <= reg_data[7];
                            per_q[FREQ_W-1:8] <= reg_data[FREQ_W-9:0];
                        end
                        default: ;
                    endcase
                end
                // A disable written on this edge wins over a tick on the same edge.
                if (!en_q || dis_wr) begin
                    div_q  <= '0;
                    step_q <= 4'd0;
                end else if (!halt_q) begin
                    if (div_q == '0) begin
                        div_q  <= per_eff;
                        step_q <= step_q + 4'd1;
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
            end
        end

        assign pulse_lvl[g] = (en_q && (mode_q || (step_q <= {1'b0, duty_q}))) ? vol_q : 4'd0;
        assign pulse_en[g]  = en_q;
    end

    if (SAW_EN != 0) begin : g_saw
        logic              ch_wr;
        logic              dis_wr;
        logic [5:0]        rate_q;
        logic              en_q;
        logic [FREQ_W-1:0] per_q;
        logic [FREQ_W-1:0] per_eff;
        logic [FREQ_W-1:0] div_q;
        logic [3:0]        cnt_q;
        logic [7:0]        acc_q;

        assign ch_wr   = reg_we && (reg_ch == 3'(NUM_PULSE)) && (reg_idx != 2'd3);
        assign dis_wr  = ch_wr && (reg_idx == 2'd2) && !reg_data[7];
        assign per_eff = x256_q ? (per_q >> 8) : (x16_q ? (per_q >> 4) : per_q);

        always_ff @(negedge m2) begin
            if (!map_rst_n) begin
                rate_q <= 6'd0;
                en_q   <= 1'b0;
                per_q  <= '0;
                div_q  <= '0;
                cnt_q  <= 4'd0;
                acc_q  <= 8'd0;
            end else begin
                if (ch_wr) begin
                    case (reg_idx)
                        2'd0: rate_q <= reg_data[5:0];
                        2'd1: per_q[7:0] <= reg_data;
                        2'd2: begin
                            en_q              <= reg_data[7];
                            per_q[FREQ_W-1:8] <= reg_data[FREQ_W-9:0];
                        end
                        default: ;
                    endcase
                end
                if (!en_q || dis_wr) begin
                    div_q <= '0;
                    cnt_q <= 4'd0;
                    acc_q <= 8'd0;
                end else if (!halt_q) begin
                    if (div_q == '0) begin
                        div_q <= per_eff;
                        // Fourteen ticks per ramp; accumulate only on odd->even steps.
                        if (cnt_q == 4'd13) begin
                            cnt_q <= 4'd0;
                            acc_q <= 8'd0;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                            if (cnt_q[0]) begin
                                acc_q <= acc_q + {2'b00, rate_q};
                            end
                        end
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
            end
        end

        assign saw_lvl = en_q ? acc_q[7:3] : 5'd0;
        assign saw_en  = en_q;
    end else begin : g_no_saw
        assign saw_lvl = 5'd0;
        assign saw_en  = 1'b0;
    end

    logic [SUM_W-1:0] mix_sum;

    always_comb begin
        mix_sum = SUM_W'(saw_lvl);
        for (int i = 0; i < NUM_PULSE; i++) begin
            mix_sum = mix_sum + SUM_W'(pulse_lvl[i]);
        end
    end

    always_ff @(negedge m2) begin
        if (!map_rst_n) begin
            snd_out <= '0;
        end else if (mix_sum > SUM_W'({OUT_W{1'b1}})) begin
            snd_out <= '1;
        end else begin
            snd_out <= mix_sum[OUT_W-1:0];
        end
    end

    assign ch_active = {saw_en, pulse_en};

endmodule

// File: tb/tb_vrc6_snd_gen.sv
// Bench for vrc6_snd_gen: directed tone scenarios plus random register traffic,
// scored against a cycle-level behavioural model of the channel rules.
module tb_vrc6_snd_gen;

    logic       m2 = 1'b0;
    logic       map_rst_n;
    logic       reg_we;
    logic [2:0] reg_ch;
    logic [1:0] reg_idx;
    logic [7:0] reg_data;
    logic [6:0] snd_out;
    logic [2:0] ch_active;
    logic [4:0] snd_sat;
    logic [2:0] ch_active_sat;

    vrc6_snd_gen #(.NUM_PULSE(2), .FREQ_W(12), .SAW_EN(1), .OUT_W(7)) dut (
        .m2(m2), .map_rst_n(map_rst_n), .reg_we(reg_we), .reg_ch(reg_ch),
        .reg_idx(reg_idx), .reg_data(reg_data), .snd_out(snd_out), .ch_active(ch_active)
    );

    vrc6_snd_gen #(.NUM_PULSE(2), .FREQ_W(12), .SAW_EN(1), .OUT_W(5)) dut_sat (
        .m2(m2), .map_rst_n(map_rst_n), .reg_we(reg_we), .reg_ch(reg_ch),
        .reg_idx(reg_idx), .reg_data(reg_data), .snd_out(snd_sat), .ch_active(ch_active_sat)
    );

    always #5 m2 = ~m2;

    int n_checks = 0;
    int n_err    = 0;

    function automatic void chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: channels 0,1 are pulses, channel 2 is the saw.
    int m_per [3];
    int m_en  [3];
    int m_div [3];
    int m_vol [2];
    int m_duty[2];
    int m_mode[2];
    int m_step[2];
    int m_rate, m_cnt, m_acc, m_halt, m_x16, m_x256;

    logic [14:0] exp_q[$];
    bit primed = 1'b0;

    function automatic int peff(int p);
        if (m_x256 != 0) return p >> 8;
        if (m_x16 != 0)  return p >> 4;
        return p;
    endfunction

    function automatic int level_sum();
        int s;
        s = 0;
        for (int i = 0; i < 2; i++) begin
            if (m_en[i] != 0 && (m_mode[i] != 0 || m_step[i] <= m_duty[i])) s += m_vol[i];
        end
        if (m_en[2] != 0) s += m_acc / 8;
        return s;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) begin
            m_per[c] = 0; m_en[c] = 0; m_div[c] = 0;
        end
        for (int c = 0; c < 2; c++) begin
            m_vol[c] = 0; m_duty[c] = 0; m_mode[c] = 0; m_step[c] = 0;
        end
        m_rate = 0; m_cnt = 0; m_acc = 0; m_halt = 0; m_x16 = 0; m_x256 = 0;
    endfunction

    always @(negedge m2) begin
        int s, a, b, act;
        bit tick, dis;
        if (!map_rst_n) begin
            model_reset();
            a = 0; b = 0; act = 0;
        end else begin
            s = level_sum();
            a = (s > 127) ? 127 : s;
            b = (s > 31) ? 31 : s;
            for (int c = 0; c < 3; c++) begin
                dis = reg_we && reg_idx == 2 && reg_ch == c && !reg_data[7];
                if (m_en[c] == 0 || dis) begin
                    m_div[c] = 0;
                    if (c < 2) m_step[c] = 0;
                    else begin m_cnt = 0; m_acc = 0; end
                end else if (m_halt == 0) begin
                    tick = (m_div[c] == 0);
                    m_div[c] = tick ? peff(m_per[c]) : m_div[c] - 1;
                    if (tick && c < 2) m_step[c] = (m_step[c] + 1) % 16;
                    if (tick && c == 2) begin
                        if (m_cnt == 13) begin
                            m_cnt = 0; m_acc = 0;
                        end else begin
                            if (m_cnt % 2 == 1) m_acc = (m_acc + m_rate) % 256;
                            m_cnt++;
                        end
                    end
                end
            end
            if (reg_we && reg_idx == 3) begin
                m_halt = reg_data[0]; m_x16 = reg_data[1]; m_x256 = reg_data[2];
            end else if (reg_we && reg_ch <= 2) begin
                case (reg_idx)
                    2'd0: if (reg_ch < 2) begin
                        m_mode[reg_ch] = reg_data[7];
                        m_duty[reg_ch] = reg_data[6:4];
                        m_vol[reg_ch]  = reg_data[3:0];
                    end else begin
                        m_rate = reg_data[5:0];
                    end
                    2'd1: m_per[reg_ch] = (m_per[reg_ch] & 'hF00) | reg_data;
                    2'd2: begin
                        m_en[reg_ch]  = reg_data[7];
                        m_per[reg_ch] = (m_per[reg_ch] & 'hFF) | (int'(reg_data[3:0]) << 8);
                    end
                    default: ;
                endcase
            end
            act = m_en[0] | (m_en[1] << 1) | (m_en[2] << 2);
        end
        exp_q.push_back({a[6:0], b[4:0], act[2:0]});
        primed = 1'b1;
    end

    // Monitor: every posedge the DUT presents the sample it registered on the last falling edge.
    always @(posedge m2) begin
        logic [14:0] e;
        if (primed) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL scoreboard_empty actual=0 expected=1 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("snd_out", int'(snd_out), int'(e[14:8]));
                chk("snd_sat", int'(snd_sat), int'(e[7:3]));
                chk("ch_active", int'(ch_active), int'(e[2:0]));
                chk("ch_active_sat", int'(ch_active_sat), int'(e[2:0]));
            end
        end
    end

    task automatic wr(input logic [2:0] ch, input logic [1:0] idx, input logic [7:0] d);
        @(posedge m2);
        reg_we = 1'b1; reg_ch = ch; reg_idx = idx; reg_data = d;
        @(posedge m2);
        reg_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge m2);
    endtask

    task automatic pulse_reset();
        @(posedge m2);
        map_rst_n = 1'b0;
        @(posedge m2);
        map_rst_n = 1'b1;
    endtask

    task automatic sample_range(input int n, output int mx_a, output int mn_a, output int mx_b);
        mx_a = 0; mn_a = 1000; mx_b = 0;
        repeat (n) begin
            @(posedge m2);
            if (int'(snd_out) > mx_a) mx_a = int'(snd_out);
            if (int'(snd_out) < mn_a) mn_a = int'(snd_out);
            if (int'(snd_sat) > mx_b) mx_b = int'(snd_sat);
        end
    endtask

    task automatic rand_write();
        int ch, idx;
        logic [7:0] d;
        ch  = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 7) : $urandom_range(0, 2);
        idx = $urandom_range(0, 3);
        d   = 8'($urandom_range(0, 255));
        if (idx == 1 && $urandom_range(0, 3) != 0) d = 8'($urandom_range(0, 6));
        if (idx == 2) begin
            if ($urandom_range(0, 7) != 0) d[3:0] = 4'd0;
            d[7] = ($urandom_range(0, 3) != 0);
        end
        if (idx == 3) d[0] = ($urandom_range(0, 4) == 0);
        wr(3'(ch), 2'(idx), d);
    endtask

    initial begin
        int mx_a, mn_a, mx_b, hi;
        map_rst_n = 1'b0; reg_we = 1'b0; reg_ch = 3'd0; reg_idx = 2'd0; reg_data = 8'd0;
        idle(3);
        map_rst_n = 1'b1;

        // Reset in the middle of a full-volume tone.
        wr(3'd0, 2'd0, 8'h9F);
        wr(3'd0, 2'd2, 8'h80);
        idle(5);
        pulse_reset();
        chk("rst_snd_out", int'(snd_out), 0);
        chk("rst_ch_active", int'(ch_active), 0);

        // Duty 3 at period 0: 4 of every 16 clocks high at volume 8.
        wr(3'd0, 2'd0, 8'h38);
        wr(3'd0, 2'd1, 8'h00);
        wr(3'd0, 2'd2, 8'h80);
        idle(5);
        hi = 0;
        repeat (32) begin
            @(posedge m2);
            if (snd_out == 7'd8) hi++;
        end
        chk("duty_high_count", hi, 8);
        wr(3'd0, 2'd2, 8'h00);
        wr(3'd0, 2'd2, 8'h80);
        idle(20);

        // Period 0x0FF, then x16, then x16+x256, then halt.
        wr(3'd0, 2'd0, 8'h78);
        wr(3'd0, 2'd1, 8'hFF);
        idle(600);
        wr(3'd0, 2'd3, 8'h02);
        idle(100);
        wr(3'd0, 2'd3, 8'h06);
        idle(40);
        wr(3'd0, 2'd3, 8'h07);
        idle(30);
        wr(3'd0, 2'd3, 8'h00);
        wr(3'd0, 2'd2, 8'h00);

        // Sawtooth rate 42 ramps 0..31 every 14 clocks; rate 43 wraps.
        wr(3'd2, 2'd0, 8'd42);
        wr(3'd2, 2'd1, 8'h00);
        wr(3'd2, 2'd2, 8'h80);
        idle(3);
        sample_range(28, mx_a, mn_a, mx_b);
        chk("saw_peak", mx_a, 31);
        chk("saw_floor", mn_a, 0);
        wr(3'd2, 2'd0, 8'd43);
        idle(30);
        wr(3'd2, 2'd0, 8'd42);
        idle(20);

        // Two full pulses plus the saw peak overflow the 5-bit instance.
        wr(3'd0, 2'd0, 8'h8F);
        wr(3'd0, 2'd2, 8'h80);
        wr(3'd1, 2'd0, 8'h8F);
        wr(3'd1, 2'd1, 8'h00);
        wr(3'd1, 2'd2, 8'h80);
        idle(3);
        sample_range(28, mx_a, mn_a, mx_b);
        chk("mix_peak_wide", mx_a, 61);
        chk("mix_peak_sat", mx_b, 31);

        // Disable landing on a tick edge.
        wr(3'd0, 2'd0, 8'h38);
        idle(3);
        wr(3'd0, 2'd2, 8'h00);
        idle(5);

        repeat (1500) begin
            if ($urandom_range(0, 99) < 2) pulse_reset();
            else if ($urandom_range(0, 99) < 40) rand_write();
            else idle(1);
        end

        idle(5);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
